// File: rtl/aes_round_ctrl.sv
// Sequencer for a shared single-round AES datapath: initial AddRoundKey, NUM_ROUNDS
// round-block passes with one key fetch each. Optional watchdog under `ROUND_TIMEOUT_EN`.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic [127:0] rnd_data_in,
  output logic [127:0] rnd_key,
  output logic         rnd_i_en,
  output logic         rnd_skip_mix_cols,
  input  logic         rnd_o_en,
  input  logic [127:0] rnd_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, ROUND, GAP, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYCLES - 1);

  fsm_t         fsm;
  logic [127:0] state_q;
  logic [3:0]   round_cnt;
  logic         err_q;
  logic         rnd_en_q;
  logic         skip_q;
  logic         out_valid_q;
  logic         busy_q;
  logic [3:0]   key_idx_q;
  logic         tmo_hit;

`ifdef ROUND_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Held at zero outside ROUND, so every ROUND entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (fsm != ROUND)  tmo_cnt <= '0;
    else if (!rnd_o_en)     tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo_hit = (fsm == ROUND) && !rnd_o_en && (tmo_cnt == TMO_LIMIT);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LIMIT;
  assign tmo_hit    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 128-bit state is reset too, so out_data reads zero after an abort.
      fsm         <= IDLE;
      state_q     <= '0;
      round_cnt   <= '0;
      err_q       <= 1'b0;
      rnd_en_q    <= 1'b0;
      skip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      key_idx_q   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_q   <= in_data ^ key_in;
            round_cnt <= 4'd1;
            err_q     <= 1'b0;
            fsm       <= ROUND;
            rnd_en_q  <= 1'b1;
            skip_q    <= (LAST_ROUND == 4'd1);
            key_idx_q <= 4'd1;
            busy_q    <= 1'b1;
          end
        end
        ROUND: begin
          if (rnd_o_en) begin
            state_q   <= rnd_data_out;
            rnd_en_q  <= 1'b0;
            skip_q    <= 1'b0;
            key_idx_q <= '0;
            if (round_cnt == LAST_ROUND) begin
              fsm         <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              round_cnt <= round_cnt + 4'd1;
              fsm       <= GAP;
            end
          end else if (tmo_hit) begin
            err_q     <= 1'b1;
            state_q   <= '0;
            round_cnt <= '0;
            fsm       <= IDLE;
            rnd_en_q  <= 1'b0;
            skip_q    <= 1'b0;
            key_idx_q <= '0;
            busy_q    <= 1'b0;
          end
        end
        GAP: begin
          // round_cnt already points at the next round here.
          fsm       <= ROUND;
          rnd_en_q  <= 1'b1;
          skip_q    <= (round_cnt == LAST_ROUND);
          key_idx_q <= round_cnt;
        end
        DONE: begin
          if (out_ready) begin
            round_cnt   <= '0;
            fsm         <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready          = (fsm == IDLE) && !rst;
  assign busy              = busy_q;
  assign key_idx           = key_idx_q;
  assign rnd_data_in       = state_q;
  assign rnd_key           = key_in;
  assign rnd_i_en          = rnd_en_q;
  assign rnd_skip_mix_cols = skip_q;
  assign out_valid         = out_valid_q;
  assign out_data          = state_q;
  assign err               = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: AES-128 key store and round-block model,
// plus an identity round stub for sequencing checks.
module tb_aes_round_ctrl;
  localparam int NR  = 10;
  localparam int TMO = 8;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ID_PT    = 128'h0123456789abcdeffedcba9876543210;
  // identity stub: keys 0..10 replicated, XOR of 0..10 is 4'hb
  localparam logic [127:0] ID_CT    = ID_PT ^ {32{4'hb}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic [127:0] rnd_data_in;
  logic [127:0] rnd_key;
  logic         rnd_i_en;
  logic         rnd_skip_mix_cols;
  logic         rnd_o_en = 1'b0;
  logic [127:0] rnd_data_out = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic         err;

  aes_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_in(key_in), .rnd_data_in(rnd_data_in), .rnd_key(rnd_key),
    .rnd_i_en(rnd_i_en), .rnd_skip_mix_cols(rnd_skip_mix_cols), .rnd_o_en(rnd_o_en),
    .rnd_data_out(rnd_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox_t   [256];
  logic [127:0] aes_keys [16];
  bit ks_aes  = 1'b0;
  bit rb_aes  = 1'b0;
  bit respond = 1'b1;
  int lat     = 3;
  int rb_cnt  = 0;

  assign key_in = ks_aes ? aes_keys[key_idx] : {32{key_idx}};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic skip);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!skip) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ k;
  endfunction

  task automatic build_tables;
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rc = 8'h01;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = FIPS_KEY[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox_t[tw[23:16]], sbox_t[tw[15:8]], sbox_t[tw[7:0]], sbox_t[tw[31:24]]}
             ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 16; r++)
      aes_keys[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Round-block model: result valid `lat` cycles after the first enabled cycle.
  always @(negedge clk) begin
    if (rnd_i_en) begin
      rb_cnt = rb_cnt + 1;
      if (respond && rb_cnt >= lat + 1) begin
        rnd_o_en     = 1'b1;
        rnd_data_out = rb_aes ? aes_round(rnd_data_in, rnd_key, rnd_skip_mix_cols)
                              : (rnd_data_in ^ rnd_key);
      end else begin
        rnd_o_en = 1'b0;
      end
    end else begin
      rb_cnt   = 0;
      rnd_o_en = 1'b0;
    end
  end

  task automatic accept_block(input logic [127:0] pt);
    @(negedge clk);
    in_data  = pt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted from and including the accept edge.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 400) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (rnd_i_en !== 1'b0 || rnd_skip_mix_cols !== 1'b0) begin n_fail++; $display("FAIL reset_rnd: en %b skip %b want 0 0", rnd_i_en, rnd_skip_mix_cols); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err: busy %b err %b want 0 0", busy, err); end
    n_checks++; if (out_data !== '0 || key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_data: out %h idx %0d want 0 0", out_data, key_idx); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fips;
    int edges = 1;
    int skip_cycles = 0;
    int skip_bad = 0;
    ks_aes = 1'b1; rb_aes = 1'b1; lat = 3; respond = 1'b1;
    accept_block(FIPS_PT);
    while (!out_valid && edges < 400) begin
      if (rnd_skip_mix_cols) begin
        skip_cycles++;
        if (key_idx !== 4'd10) skip_bad++;
      end
      @(posedge clk); #1;
      edges++;
    end
    n_checks++; if (edges != 50) begin n_fail++; $display("FAIL fips_latency: got %0d want 50", edges); end
    n_checks++; if (out_data !== FIPS_CT) begin n_fail++; $display("FAIL fips_ct: got %h want %h", out_data, FIPS_CT); end
    n_checks++; if (skip_cycles != 4 || skip_bad != 0) begin n_fail++; $display("FAIL fips_skip: cycles %0d bad %0d want 4 0", skip_cycles, skip_bad); end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    int edges;
    logic [127:0] held = out_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data  = ~held;
      @(posedge clk); #1;
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable: %0d bad cycles want 0", bad); end
    n_checks++; if (out_data !== FIPS_CT) begin n_fail++; $display("FAIL hold_data: got %h want %h", out_data, FIPS_CT); end
    release_out;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_idle: ready %b valid %b want 1 0", in_ready, out_valid); end
    accept_block(FIPS_PT);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %b want 1", busy); end
    wait_done(edges);
    n_checks++; if (edges != 50 || out_data !== FIPS_CT) begin n_fail++; $display("FAIL b2b_result: edges %0d data %h want 50 %h", edges, out_data, FIPS_CT); end
    release_out;
  endtask

  task automatic test_key_sequence;
    int edges = 1;
    int nrounds = 0, gap = 0, gap_bad = 0, seq_bad = 0, idx_bad = 0, skip_bad = 0;
    logic prev_en = 1'b0;
    ks_aes = 1'b0; rb_aes = 1'b0; lat = 1; respond = 1'b1;
    @(negedge clk);
    n_checks++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL idle_key_idx: got %0d want 0", key_idx); end
    accept_block(ID_PT);
    while (!out_valid && edges < 400) begin
      if (rnd_i_en && !prev_en) begin
        if (nrounds > 0 && gap != 1) gap_bad++;
        if (key_idx !== 4'(nrounds + 1)) seq_bad++;
        nrounds++;
        gap = 0;
      end
      if (!rnd_i_en) begin
        gap++;
        if (key_idx !== 4'd0) idx_bad++;
      end
      if (rnd_skip_mix_cols && key_idx !== 4'd10) skip_bad++;
      prev_en = rnd_i_en;
      @(posedge clk); #1;
      edges++;
    end
    n_checks++; if (nrounds != 10 || seq_bad != 0) begin n_fail++; $display("FAIL key_seq: rounds %0d bad %0d want 10 0", nrounds, seq_bad); end
    n_checks++; if (gap_bad != 0 || idx_bad != 0 || skip_bad != 0) begin n_fail++; $display("FAIL gaps: gap %0d idx %0d skip %0d want 0 0 0", gap_bad, idx_bad, skip_bad); end
    n_checks++; if (edges != 30) begin n_fail++; $display("FAIL l1_latency: got %0d want 30", edges); end
    n_checks++; if (out_data !== ID_CT) begin n_fail++; $display("FAIL id_result: got %h want %h", out_data, ID_CT); end
    release_out;
  endtask

  task automatic test_reset_midop;
    int n = 0;
    int edges;
    bit ov_seen = 1'b0;
    ks_aes = 1'b1; rb_aes = 1'b1; lat = 3; respond = 1'b1;
    accept_block(FIPS_PT);
    while (!(rnd_i_en && key_idx == 4'd5) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++; if (key_idx !== 4'd5 || rnd_i_en !== 1'b1) begin n_fail++; $display("FAIL reach_round5: idx %0d en %b want 5 1", key_idx, rnd_i_en); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rnd_i_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_async: en %b busy %b ready %b want 0 0 0", rnd_i_en, busy, in_ready); end
    n_checks++; if (out_data !== '0 || key_idx !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_state: out %h idx %0d valid %b want 0", out_data, key_idx, out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    n_checks++; if (ov_seen || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_output: valid_seen %b busy %b want 0 0", ov_seen, busy); end
    accept_block(FIPS_PT);
    wait_done(edges);
    n_checks++; if (edges != 50 || out_data !== FIPS_CT) begin n_fail++; $display("FAIL after_abort: edges %0d data %h want 50 %h", edges, out_data, FIPS_CT); end
    release_out;
  endtask

`ifdef ROUND_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    int edges;
    bit ov_seen = 1'b0;
    ks_aes = 1'b0; rb_aes = 1'b0; lat = 1; respond = 1'b0;
    accept_block(ID_PT);
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) ov_seen = 1'b1;
    end
    n_checks++; if (n != 8) begin n_fail++; $display("FAIL tmo_cycles: got %0d want 8", n); end
    n_checks++; if (err !== 1'b1 || in_ready !== 1'b1 || ov_seen) begin n_fail++; $display("FAIL tmo_state: err %b ready %b valid_seen %b want 1 1 0", err, in_ready, ov_seen); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL tmo_clear: got %h want 0", out_data); end
    respond = 1'b1;
    accept_block(ID_PT);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err); end
    wait_done(edges);
    n_checks++; if (out_data !== ID_CT) begin n_fail++; $display("FAIL tmo_recover: got %h want %h", out_data, ID_CT); end
    release_out;
  endtask

  task automatic test_timeout_limit;
    int edges;
    ks_aes = 1'b0; rb_aes = 1'b0; lat = 7; respond = 1'b1;
    accept_block(ID_PT);
    wait_done(edges);
    n_checks++; if (edges != 90 || err !== 1'b0) begin n_fail++; $display("FAIL limit_win: edges %0d err %b want 90 0", edges, err); end
    n_checks++; if (out_data !== ID_CT) begin n_fail++; $display("FAIL limit_result: got %h want %h", out_data, ID_CT); end
    release_out;
  endtask
`else
  task automatic test_stall;
    int edges;
    ks_aes = 1'b0; rb_aes = 1'b0; lat = 1; respond = 1'b0;
    accept_block(ID_PT);
    repeat (100) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1 || rnd_i_en !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait: busy %b en %b err %b valid %b want 1 1 0 0", busy, rnd_i_en, err, out_valid); end
    respond = 1'b1;
    wait_done(edges);
    n_checks++; if (out_valid !== 1'b1 || out_data !== ID_CT) begin n_fail++; $display("FAIL stall_result: valid %b data %h want 1 %h", out_valid, out_data, ID_CT); end
    release_out;
  endtask
`endif

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_back_to_back();
    test_key_sequence();
    test_reset_midop();
`ifdef ROUND_TIMEOUT_EN
    test_timeout();
    test_timeout_limit();
`else
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
